// File: rtl/dmem_unit_pkg.sv
// Shared encodings for the data-memory unit: access types, access sizes and the MMIO map.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package dmem_unit_pkg;

  // Load/store access type as carried by the MEM stage; 101-111 behave as word.
  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  // MMIO window: addr[31:16] == MMIO_BASE, register selected by addr[15:0].
  localparam logic [15:0] MMIO_BASE   = 16'hFFFF;
  localparam logic [15:0] MMIO_CYCLE  = 16'h0000;
  localparam logic [15:0] MMIO_TXDATA = 16'h0004;
  localparam logic [15:0] MMIO_STATUS = 16'h0008;

  function automatic acc_size_e acc_size(input logic [2:0] t);
    acc_size_e sz;
    case (t)
      DM_HALF, DM_HALF_U: sz = SZ_HALF;
      DM_BYTE, DM_BYTE_U: sz = SZ_BYTE;
      default:            sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input acc_size_e sz, input logic [1:0] lo);
    logic m;
    case (sz)
      SZ_HALF: m = lo[0];
      SZ_WORD: m = (lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_unit_cons_fifo.sv
// Console byte FIFO: 2**AW entries, head visible combinationally on dout (0 when empty).
// Latency: a pushed byte is at the head one edge after the push if the FIFO was empty.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped and flagged.
//
// Ports: clk, rst (async, active-low), push/din (enqueue), pop (dequeue, ignored when empty),
//        dout (head), empty, full, count (0..2**AW), overflow_set (pulse: this cycle's push was dropped).
module cons_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overflow_set
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop_eff;
  logic             push_eff;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH[AW:0]);
  assign pop_eff = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs, so full does not block it.
  assign push_eff     = push & (~full | pop_eff);
  assign overflow_set = push & full & ~pop_eff;
  assign dout         = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage target: byte/half/word RAM access with extension, store lane merge, MMIO cycle/console.
// Latency: loads are combinational (0 cycles); stores, FIFO pushes and flags update at the next rising edge.
// Backpressure: never stalls the pipeline; console bytes pushed into a full FIFO are dropped and flagged.
//
// Ports: clk, rst (async, active-low); mem_w/mem_r/addr/din/dm_type from the MEM stage; dout load data;
//        misalign sticky flag; cons_data/cons_valid/cons_ready console TX handshake.
module dmem_unit
  import dmem_unit_pkg::*;
#(
  parameter int DEPTH_W = 8,
  parameter int FIFO_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [2:0]  dm_type,
  output logic [31:0] dout,
  output logic        misalign,
  output logic [7:0]  cons_data,
  output logic        cons_valid,
  input  logic        cons_ready
);

  logic [31:0] ram [2**DEPTH_W];

  acc_size_e          sz;
  logic               mis;
  logic               is_mmio;
  logic [DEPTH_W-1:0] word_idx;
  logic [31:0]        rd_word;
  logic [31:0]        lane;
  logic [31:0]        ext;
  logic [31:0]        status;
  logic [31:0]        wdata;
  logic [3:0]         wbe;
  logic               ram_we;
  logic               tx_push;
  logic               status_rd;

  logic [31:0]        cycle_cnt;
  logic               overflow;
  logic               fifo_empty;
  logic               fifo_full;
  logic [FIFO_W:0]    fifo_count;
  logic               overflow_set;

  assign sz       = acc_size(dm_type);
  assign mis      = misaligned(sz, addr[1:0]);
  assign is_mmio  = (addr[31:16] == MMIO_BASE);
  // Upper address bits above the RAM index are ignored, so RAM aliases across the non-MMIO space.
  assign word_idx = addr[DEPTH_W+1:2];

  assign tx_push   = mem_w & ~mis & is_mmio & (addr[15:0] == MMIO_TXDATA);
  assign status_rd = mem_r & ~mis & is_mmio & (addr[15:0] == MMIO_STATUS);
  assign ram_we    = mem_w & ~mis & ~is_mmio;

  always_comb begin
    status                = '0;
    status[FIFO_W:0]      = fifo_count;
    status[FIFO_W+1]      = overflow;
  end

  // Read path: pick the source word, shift the addressed lane down, then extend.
  always_comb begin
    rd_word = '0;
    if (is_mmio) begin
      case (addr[15:0])
        MMIO_CYCLE:  rd_word = cycle_cnt;
        MMIO_STATUS: rd_word = status;
        default:     rd_word = '0;
      endcase
    end else begin
      rd_word = ram[word_idx];
    end
    lane = rd_word >> {addr[1:0], 3'b000};
    case (dm_type)
      DM_HALF:   ext = {{16{lane[15]}}, lane[15:0]};
      DM_HALF_U: ext = {16'h0000, lane[15:0]};
      DM_BYTE:   ext = {{24{lane[7]}}, lane[7:0]};
      DM_BYTE_U: ext = {24'h000000, lane[7:0]};
      default:   ext = lane;
    endcase
    dout = (mem_r & ~mis) ? ext : '0;
  end

  // Write path: store data is right-aligned, so move it up into the addressed lanes.
  always_comb begin
    wdata = din << {addr[1:0], 3'b000};
    case (sz)
      SZ_BYTE: wbe = 4'b0001 << addr[1:0];
      SZ_HALF: wbe = 4'b0011 << addr[1:0];
      default: wbe = 4'b1111;
    endcase
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) begin
          ram[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      misalign  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if ((mem_w | mem_r) & mis) begin
        misalign <= 1'b1;
      end
      // A fresh overflow beats the clear-on-read of STATUS.
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (status_rd) begin
        overflow <= 1'b0;
      end
    end
  end

  cons_fifo #(
    .WIDTH (8),
    .AW    (FIFO_W)
  ) u_cons_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (tx_push),
    .din          (din[7:0]),
    .pop          (cons_ready),
    .dout         (cons_data),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .count        (fifo_count),
    .overflow_set (overflow_set)
  );

  assign cons_valid = ~fifo_empty;

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: directed scenarios plus randomized traffic against a byte-level reference model.
// Latency: n/a.
// Backpressure: drives cons_ready randomly and in directed stall/drain patterns.
module tb_dmem_unit;

  logic        clk;
  logic        rst;
  logic        mem_w;
  logic        mem_r;
  logic [31:0] addr;
  logic [31:0] din;
  logic [2:0]  dm_type;
  logic [31:0] dout;
  logic        misalign;
  logic [7:0]  cons_data;
  logic        cons_valid;
  logic        cons_ready;

  dmem_unit #(.DEPTH_W(8), .FIFO_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_w      (mem_w),
    .mem_r      (mem_r),
    .addr       (addr),
    .din        (din),
    .dm_type    (dm_type),
    .dout       (dout),
    .misalign   (misalign),
    .cons_data  (cons_data),
    .cons_valid (cons_valid),
    .cons_ready (cons_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: 1 KiB of bytes, console queue, flags, elapsed cycles.
  logic [7:0]  mm [0:1023];
  logic [7:0]  q [$];
  bit          ovf;
  bit          misf;
  logic [31:0] cyc;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int sz_of(input logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return 2;
    if (t == 3'd3 || t == 3'd4) return 1;
    return 4;
  endfunction

  // Aligned load value straight from the address map and the extension rules.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t);
    int s = sz_of(t);
    logic [31:0] raw = 32'h0;
    logic [31:0] mask;
    if (a[31:16] == 16'hFFFF) begin
      if (a == 32'hFFFF_0000) raw = cyc;
      else if (a == 32'hFFFF_0008) raw = 32'(q.size()) + (ovf ? 32'h8 : 32'h0);
    end else begin
      for (int k = 0; k < s; k++) raw = raw | (32'(mm[int'(a[9:0]) + k]) << (8 * k));
    end
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * s)) - 32'h1);
    raw  = raw & mask;
    if ((t == 3'd1 || t == 3'd3) && raw[8*s-1]) raw = raw | ~mask;
    return raw;
  endfunction

  // One clock: drive, check outputs before the edge, then advance the model across the edge.
  task automatic op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] t, input logic rdy, output logic [31:0] got);
    int s;
    bit misn, pop_e, push_e, stat_e, full_pre, oset;
    logic [31:0] exp_d, exp_cd;
    mem_w = w; mem_r = r; addr = a; din = d; dm_type = t; cons_ready = rdy;
    #1;
    s      = sz_of(t);
    misn   = (w || r) && ((int'(a[1:0]) % s) != 0);
    exp_d  = (r && !misn) ? model_load(a, t) : 32'h0;
    exp_cd = (q.size() != 0) ? 32'(q[0]) : 32'h0;
    got    = dout;
    chk("dout", dout, exp_d);
    chk("misalign", 32'(misalign), 32'(misf));
    chk("cons_valid", 32'(cons_valid), 32'(q.size() != 0));
    chk("cons_data", 32'(cons_data), exp_cd);
    @(posedge clk);
    full_pre = (q.size() == 4);
    pop_e    = (q.size() != 0) && rdy;
    push_e   = w && !misn && (a == 32'hFFFF_0004);
    stat_e   = r && !misn && (a == 32'hFFFF_0008);
    oset     = 1'b0;
    if (pop_e) void'(q.pop_front());
    if (push_e) begin
      if (full_pre && !pop_e) oset = 1'b1;
      else q.push_back(d[7:0]);
    end
    if (oset) ovf = 1'b1;
    else if (stat_e) ovf = 1'b0;
    if (misn) misf = 1'b1;
    if (w && !misn && a[31:16] != 16'hFFFF)
      for (int k = 0; k < s; k++) mm[int'(a[9:0]) + k] = 8'(d >> (8 * k));
    cyc = cyc + 32'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    mem_w = 1'b0; mem_r = 1'b1; addr = 32'hFFFF_0000; dm_type = 3'd0; cons_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_cons_valid", 32'(cons_valid), 32'h0);
    chk("rst_cons_data", 32'(cons_data), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_cycle_read", dout, 32'h0);
    q.delete(); ovf = 1'b0; misf = 1'b0; cyc = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; mem_r = 1'b0;
  endtask

  localparam logic [31:0] A_CYC = 32'hFFFF_0000;
  localparam logic [31:0] A_TX  = 32'hFFFF_0004;
  localparam logic [31:0] A_ST  = 32'hFFFF_0008;

  initial begin
    logic [31:0] g;
    logic [7:0]  letters [5];
    letters[0] = 8'h41; letters[1] = 8'h42; letters[2] = 8'h43; letters[3] = 8'h44; letters[4] = 8'h45;
    for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
    q.delete(); ovf = 1'b0; misf = 1'b0; cyc = 32'h0;
    rst = 1'b0; mem_w = 1'b0; mem_r = 1'b0; addr = 32'h0; din = 32'h0; dm_type = 3'd0; cons_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-stream: FIFO holding 3, CYCLE at 100, RAM word must survive.
    op(1, 0, 32'h40, 32'hCAFE_F00D, 3'd0, 0, g);
    for (int i = 0; i < 3; i++) op(1, 0, A_TX, 32'h30 + i, 3'd0, 0, g);
    while (cyc < 32'd100) op(0, 0, 32'h0, 32'h0, 3'd0, 0, g);
    op(0, 1, A_CYC, 32'h0, 3'd0, 0, g);
    chk("cycle_100", g, 32'd100);
    chk("fifo_before_rst", 32'(cons_valid), 32'h1);
    do_reset();
    op(0, 1, A_CYC, 32'h0, 3'd0, 0, g);
    chk("cycle_after_rst0", g, 32'd0);
    op(0, 1, A_CYC, 32'h0, 3'd0, 0, g);
    chk("cycle_after_rst1", g, 32'd1);
    op(0, 1, 32'h40, 32'h0, 3'd0, 0, g);
    chk("ram_kept", g, 32'hCAFE_F00D);

    // Fill the whole RAM so random loads have defined data.
    for (int i = 0; i < 256; i++) op(1, 0, 32'(i * 4), $urandom, 3'd0, 0, g);

    // Extension.
    op(1, 0, 32'h10, 32'h8000_80F0, 3'd0, 0, g);
    op(0, 1, 32'h10, 32'h0, 3'd3, 0, g); chk("lb_10", g, 32'hFFFF_FFF0);
    op(0, 1, 32'h13, 32'h0, 3'd4, 0, g); chk("lbu_13", g, 32'h0000_0080);
    op(0, 1, 32'h12, 32'h0, 3'd1, 0, g); chk("lh_12", g, 32'hFFFF_8000);
    op(0, 1, 32'h10, 32'h0, 3'd2, 0, g); chk("lhu_10", g, 32'h0000_80F0);

    // Lane merge.
    op(1, 0, 32'h20, 32'h1122_3344, 3'd0, 0, g);
    op(1, 0, 32'h21, 32'h0000_00AA, 3'd3, 0, g);
    op(0, 1, 32'h20, 32'h0, 3'd0, 0, g); chk("sb_merge", g, 32'h1122_AA44);
    op(1, 0, 32'h22, 32'h0000_BEEF, 3'd1, 0, g);
    op(0, 1, 32'h20, 32'h0, 3'd0, 0, g); chk("sh_merge", g, 32'hBEEF_AA44);

    // Misalignment.
    op(0, 1, 32'h22, 32'h0, 3'd0, 0, g); chk("mis_load_zero", g, 32'h0);
    chk("mis_flag_set", 32'(misalign), 32'h1);
    op(1, 0, 32'h21, 32'hDEAD_BEEF, 3'd0, 0, g);
    op(0, 1, 32'h20, 32'h0, 3'd0, 0, g); chk("mis_store_supp", g, 32'hBEEF_AA44);
    chk("mis_sticky", 32'(misalign), 32'h1);
    do_reset();
    chk("mis_cleared", 32'(misalign), 32'h0);

    // Console overflow and drain.
    for (int i = 0; i < 5; i++) op(1, 0, A_TX, 32'(letters[i]), 3'd0, 0, g);
    op(0, 1, A_ST, 32'h0, 3'd0, 0, g); chk("status_ovf", g, 32'h0000_000C);
    for (int i = 0; i < 4; i++) begin
      chk("drain_byte", 32'(cons_data), 32'(letters[i]));
      op(0, 0, 32'h0, 32'h0, 3'd0, 1, g);
    end
    chk("drain_empty", 32'(cons_valid), 32'h0);
    op(0, 1, A_ST, 32'h0, 3'd0, 0, g); chk("status_cleared", g, 32'h0);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) op(1, 0, A_TX, 32'(i), 3'd0, 0, g);
    op(1, 0, A_TX, 32'h55, 3'd0, 1, g);
    op(0, 1, A_ST, 32'h0, 3'd0, 0, g); chk("full_pushpop", g, 32'h0000_0004);
    chk("head_advanced", 32'(cons_data), 32'h2);
    for (int i = 0; i < 4; i++) op(0, 0, 32'h0, 32'h0, 3'd0, 1, g);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      logic [2:0]  t;
      int          s;
      t = 3'($urandom_range(0, 7));
      s = sz_of(t);
      if ($urandom_range(0, 9) < 6)
        a = {16'($urandom_range(0, 16'hFFFE)), 6'($urandom), 10'($urandom)};
      else
        a = 32'hFFFF_0000 | 32'(4 * $urandom_range(0, 3)) | 32'($urandom_range(0, 9) == 0 ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 19) != 0) a = a & ~32'(s - 1);
      if ($urandom_range(0, 99) == 0) do_reset();
      op(1'($urandom), 1'($urandom), a, $urandom, t, 1'($urandom_range(0, 2) == 0), g);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
